// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the panel power-rail sequencer: state encoding,
// rail polarity, default step delays and per-state rail decode helpers.
package pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_UP_AVDD = 3'd1,
    ST_UP_GATE = 3'd2,
    ST_UP_MUX  = 3'd3,
    ST_ON      = 3'd4,
    ST_DN_MUX  = 3'd5,
    ST_DN_GATE = 3'd6,
    ST_DISCHG  = 3'd7
  } pwr_state_t;

  localparam logic RAIL_ON  = 1'b0;
  localparam logic RAIL_OFF = 1'b1;

  localparam logic [15:0] T_AVDD_MS_DEF   = 16'd10;
  localparam logic [15:0] T_GATE_MS_DEF   = 16'd500;
  localparam logic [15:0] T_MUX_MS_DEF    = 16'd5;
  localparam logic [15:0] T_DOWN_MS_DEF   = 16'd50;
  localparam logic [15:0] T_DISCHG_MS_DEF = 16'd10;

  function automatic logic avdd_on(input pwr_state_t s);
    return s inside {ST_UP_AVDD, ST_UP_GATE, ST_UP_MUX, ST_ON, ST_DN_MUX, ST_DN_GATE};
  endfunction

  function automatic logic gate_on(input pwr_state_t s);
    return s inside {ST_UP_GATE, ST_UP_MUX, ST_ON, ST_DN_MUX};
  endfunction

  function automatic logic mux_on(input pwr_state_t s);
    return s inside {ST_UP_MUX, ST_ON};
  endfunction

endpackage

// File: rtl/pwr_ms_timer.sv
// Millisecond step timer: us prescaler, ms prescaler and 16-bit ms counter,
// restarted by clear in the first cycle of each sequencer state.
module pwr_ms_timer #(
  parameter int unsigned CLK_PER_US = 81,
  parameter int unsigned US_PER_MS  = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [15:0] tlen,
  output logic        done
);

  localparam int unsigned UW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned PW = (US_PER_MS > 1) ? $clog2(US_PER_MS) : 1;
  localparam logic [UW-1:0] US_LAST  = UW'(CLK_PER_US - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(US_PER_MS - 1);

  logic [UW-1:0] us_cnt, us_e;
  logic [PW-1:0] pre_cnt, pre_e;
  logic [15:0]   ms_cnt, ms_e;
  logic          us_wrap, pre_wrap;

  // clear acts on the current cycle, so the entry cycle already counts as elapsed cycle 0
  assign us_e  = clear ? '0 : us_cnt;
  assign pre_e = clear ? '0 : pre_cnt;
  assign ms_e  = clear ? '0 : ms_cnt;

  assign us_wrap  = (us_e == US_LAST);
  assign pre_wrap = (pre_e == PRE_LAST);

  assign done = (tlen == 16'd0) ? clear
                                : (us_wrap && pre_wrap && (ms_e == tlen - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt  <= '0;
      pre_cnt <= '0;
      ms_cnt  <= '0;
    end else begin
      us_cnt  <= us_wrap ? '0 : us_e + 1'b1;
      pre_cnt <= us_wrap ? (pre_wrap ? '0 : pre_e + 1'b1) : pre_e;
      ms_cnt  <= (us_wrap && pre_wrap) ? ms_e + 16'd1 : ms_e;
    end
  end

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Panel power-rail sequencer: ordered AVDD/gate/mux power-up, reverse power-down,
// fast-off discharge. Optional rail-fault input under PWR_SEQ_FAULT_EN.
//
// state      | meaning
// OFF        | all rails off, waiting for on request
// UP_AVDD    | AVDD on, settling before gate rails
// UP_GATE    | gate rails on, settling before mux enable
// UP_MUX     | mux enables on, settling before pwr_good
// ON         | fully powered, pwr_good high
// DN_MUX     | mux off, gate rails still on
// DN_GATE    | gate rails off, AVDD still on
// DISCHG     | all rails off, discharge hold
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned CLK_PER_US  = 81,
  parameter int unsigned US_PER_MS   = 1000,
  parameter logic [15:0] T_AVDD_MS   = T_AVDD_MS_DEF,
  parameter logic [15:0] T_GATE_MS   = T_GATE_MS_DEF,
  parameter logic [15:0] T_MUX_MS    = T_MUX_MS_DEF,
  parameter logic [15:0] T_DOWN_MS   = T_DOWN_MS_DEF,
  parameter logic [15:0] T_DISCHG_MS = T_DISCHG_MS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pwr_on_req,
  input  logic       pwr_off_req,
  input  logic       fast_off,
  output logic       en_p14v,
  output logic       en_n14v,
  output logic       en_gvddp,
  output logic       en_gvddn,
  output logic       en_vgh,
  output logic       en_vgl,
  output logic [3:0] mux_en,
  output logic [1:0] mux_en_test,
  output logic       pwr_good,
  output logic       busy,
  output logic [2:0] pwr_state
`ifdef PWR_SEQ_FAULT_EN
  ,
  input  logic       pwr_fault,
  output logic       fault_sticky
`endif
);

  pwr_state_t  state, nxt;
  logic        tmr_clr, tmr_done, restart;
  logic [15:0] tlen;
  logic        pend_on, on_ok, fault_kill, kill;

`ifdef PWR_SEQ_FAULT_EN
  logic flt_s1, flt_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_s1       <= 1'b0;
      flt_s2       <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      flt_s1 <= pwr_fault;
      flt_s2 <= flt_s1;
      if (fault_kill)
        fault_sticky <= 1'b1;
      else if (pwr_off_req && state == ST_OFF)
        fault_sticky <= 1'b0;
    end
  end

  assign fault_kill = flt_s2 && !(state inside {ST_OFF, ST_DISCHG});
  assign on_ok      = pwr_on_req && !fault_sticky;
`else
  assign fault_kill = 1'b0;
  assign on_ok      = pwr_on_req;
`endif

  assign kill      = (fast_off && state != ST_OFF) || fault_kill;
  assign pwr_state = state;

  always_comb begin
    tlen = 16'd0;
    case (state)
      ST_UP_AVDD:           tlen = T_AVDD_MS;
      ST_UP_GATE:           tlen = T_GATE_MS;
      ST_UP_MUX, ST_DN_MUX: tlen = T_MUX_MS;
      ST_DN_GATE:           tlen = T_DOWN_MS;
      ST_DISCHG:            tlen = T_DISCHG_MS;
      default:              tlen = 16'd0;
    endcase
  end

  always_comb begin
    nxt = state;
    if (kill) begin
      nxt = ST_DISCHG;
    end else begin
      case (state)
        ST_OFF:     if (!pwr_off_req && (on_ok || pend_on)) nxt = ST_UP_AVDD;
        ST_UP_AVDD: if (pwr_off_req) nxt = ST_DN_GATE;
                    else if (tmr_done) nxt = ST_UP_GATE;
        ST_UP_GATE: if (pwr_off_req) nxt = ST_DN_MUX;
                    else if (tmr_done) nxt = ST_UP_MUX;
        ST_UP_MUX:  if (pwr_off_req) nxt = ST_DN_MUX;
                    else if (tmr_done) nxt = ST_ON;
        ST_ON:      if (pwr_off_req) nxt = ST_DN_MUX;
        ST_DN_MUX:  if (tmr_done) nxt = ST_DN_GATE;
        ST_DN_GATE: if (tmr_done) nxt = ST_DISCHG;
        ST_DISCHG:  if (tmr_done) nxt = ST_OFF;
        default:    nxt = ST_OFF;
      endcase
    end
  end

  // a repeated fast-off in DISCHG re-arms the discharge hold
  assign restart = kill || (nxt != state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_OFF;
      tmr_clr     <= 1'b1;
      pend_on     <= 1'b0;
      en_p14v     <= RAIL_OFF;
      en_n14v     <= RAIL_OFF;
      en_gvddp    <= RAIL_OFF;
      en_gvddn    <= RAIL_OFF;
      en_vgh      <= RAIL_OFF;
      en_vgl      <= RAIL_OFF;
      mux_en      <= 4'h0;
      mux_en_test <= 2'b00;
      pwr_good    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt;
      tmr_clr     <= restart;
      en_p14v     <= avdd_on(nxt) ? RAIL_ON : RAIL_OFF;
      en_n14v     <= avdd_on(nxt) ? RAIL_ON : RAIL_OFF;
      en_gvddp    <= gate_on(nxt) ? RAIL_ON : RAIL_OFF;
      en_gvddn    <= gate_on(nxt) ? RAIL_ON : RAIL_OFF;
      en_vgh      <= gate_on(nxt) ? RAIL_ON : RAIL_OFF;
      en_vgl      <= gate_on(nxt) ? RAIL_ON : RAIL_OFF;
      mux_en      <= mux_on(nxt) ? 4'hF : 4'h0;
      mux_en_test <= mux_on(nxt) ? 2'b11 : 2'b00;
      pwr_good    <= (nxt == ST_ON);
      busy        <= !(nxt inside {ST_OFF, ST_ON});
      if (kill || pwr_off_req)
        pend_on <= 1'b0;
      else if (on_ok && (state inside {ST_DN_MUX, ST_DN_GATE, ST_DISCHG}))
        pend_on <= 1'b1;
      else if (state == ST_OFF && nxt == ST_UP_AVDD)
        pend_on <= 1'b0;
    end
  end

  pwr_ms_timer #(
    .CLK_PER_US (CLK_PER_US),
    .US_PER_MS  (US_PER_MS)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tmr_clr),
    .tlen  (tlen),
    .done  (tmr_done)
  );

endmodule
